// File: rtl/amiq_muxn_arb_pkg.sv
// Shared types and helpers for the N-channel registered mux / arbiter.
//   mode_e        : SEL (fixed select) or RR (round-robin) operation.
//   lock_e        : packet-lock state for round-robin mode.
//   rr_first_one  : rotating first-one search starting after a pointer.
package amiq_muxn_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned MAX_PW = 4;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_e;

  // Returns {found, index}. The search starts at ptr+1 and wraps modulo n,
  // so the channel at ptr itself has the lowest priority.
  function automatic logic [MAX_PW:0] rr_first_one(
    input logic [MAX_CH-1:0] req,
    input logic [MAX_PW-1:0] ptr,
    input int unsigned       n
  );
    logic [MAX_PW:0] res;
    int unsigned     idx;
    res = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!res[MAX_PW] && req[idx[MAX_PW-1:0]]) begin
        res = {1'b1, idx[MAX_PW-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/amiq_muxn_arb_if.sv
// Handshake bundle between the producers, the mux and the consumer.
//   mode/sel                      : selection control
//   in_valid/in_data/in_last      : N_CH producer channels (data packed, ch i at [i*DATA_W +: DATA_W])
//   in_ready                      : per-channel ready from the mux
//   out_valid/out_data/out_last   : registered output beat
//   out_chan                      : source channel of the held beat
//   out_ready                     : consumer ready
// master = producer/consumer side, slave = the mux.
interface amiq_muxn_arb_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int PW = $clog2(N_CH);

  logic                     mode;
  logic [PW-1:0]            sel;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_last;
  logic [N_CH-1:0]          in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [PW-1:0]            out_chan;
  logic                     out_ready;

  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );

endinterface

// File: rtl/amiq_muxn_arb_rr_arbiter.sv
// Combinational round-robin arbiter with optional grant lock.
//   req         : per-channel request
//   ptr         : last granted channel (lowest priority this round)
//   lock_en     : force the grant to lock_ch
//   lock_ch     : channel holding the lock
//   grant       : granted channel index
//   grant_valid : a grant exists this cycle
module amiq_rr_arbiter
  import amiq_muxn_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int PW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            lock_en,
  input  logic [PW-1:0]   lock_ch,
  output logic [PW-1:0]   grant,
  output logic            grant_valid
);

  logic [MAX_CH-1:0] w_req_ext;
  logic [MAX_PW:0]   w_search;

  always_comb begin
    w_req_ext           = '0;
    w_req_ext[N_CH-1:0] = req;
    w_search            = rr_first_one(w_req_ext, MAX_PW'(ptr), N_CH);
    if (lock_en) begin
      // Locked: only the owner may transfer; its bubbles yield no grant.
      grant       = lock_ch;
      grant_valid = req[lock_ch];
    end else begin
      grant       = w_search[PW-1:0];
      grant_valid = w_search[MAX_PW];
    end
  end

endmodule

// File: rtl/amiq_muxn_arb.sv
// N-channel registered mux with fixed-select and round-robin modes.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : amiq_muxn_arb_if slave (mode, sel, per-channel valid/data/last/ready,
//         registered out_valid/out_data/out_last/out_chan, out_ready)
// One-deep output register; a new beat loads whenever the register is empty
// or being drained, giving full throughput.
module amiq_muxn_arb
  import amiq_muxn_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 8,
  parameter int PKT_LOCK = 1
) (
  input  logic           clk,
  input  logic           rst,
  amiq_muxn_arb_if.slave bus
);

  localparam int PW = $clog2(N_CH);

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic [PW-1:0]       r_out_chan;
  logic [PW-1:0]       r_rr_ptr;
  lock_e               r_lock;
  logic [PW-1:0]       r_lock_ch;

  mode_e               w_mode;
  logic                w_accept;
  logic                w_lock_en;
  logic [PW-1:0]       w_rr_grant;
  logic                w_rr_gv;
  logic                w_sel_gv;
  logic [PW-1:0]       w_grant;
  logic                w_grant_valid;
  logic [N_CH-1:0]     w_in_ready;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_last;

  assign w_mode    = mode_e'(bus.mode);
  assign w_accept  = !r_out_valid || bus.out_ready;
  // A held lock is ignored as soon as SEL mode is selected; it is cleared on the next edge.
  assign w_lock_en = (r_lock == LK_LOCKED) && (w_mode == MODE_RR);

  amiq_rr_arbiter #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_arb (
    .req         (bus.in_valid),
    .ptr         (r_rr_ptr),
    .lock_en     (w_lock_en),
    .lock_ch     (r_lock_ch),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_gv)
  );

  // Out-of-range sel (non power-of-two N_CH) yields no grant.
  assign w_sel_gv = (32'(bus.sel) < N_CH) && bus.in_valid[bus.sel];

  always_comb begin
    if (w_mode == MODE_RR) begin
      w_grant       = w_rr_grant;
      w_grant_valid = w_rr_gv;
    end else begin
      w_grant       = bus.sel;
      w_grant_valid = w_sel_gv;
    end
  end

  always_comb begin
    w_in_ready = '0;
    if (!rst && w_accept && w_grant_valid) begin
      w_in_ready[w_grant] = 1'b1;
    end
  end

  assign w_xfer       = |(bus.in_valid & w_in_ready);
  assign w_sel_data   = bus.in_data[32'(w_grant)*DATA_W +: DATA_W];
  assign w_sel_last   = bus.in_last[w_grant];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_chan  = r_out_chan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_chan  <= '0;
      r_rr_ptr    <= PW'(N_CH - 1);
      r_lock      <= LK_IDLE;
      r_lock_ch   <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_sel_data;
          r_out_last <= w_sel_last;
          r_out_chan <= w_grant;
        end
      end

      if (w_xfer && (w_mode == MODE_RR)) begin
        r_rr_ptr <= w_grant;
      end

      if (w_mode == MODE_SEL) begin
        r_lock <= LK_IDLE;
      end else if ((PKT_LOCK != 0) && w_xfer) begin
        if (r_lock == LK_IDLE && !w_sel_last) begin
          r_lock    <= LK_LOCKED;
          r_lock_ch <= w_grant;
        end else if (r_lock == LK_LOCKED && w_sel_last) begin
          r_lock <= LK_IDLE;
        end
      end
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(bus.in_ready))
    else $error("in_ready not one-hot or zero");

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (r_out_valid && !bus.out_ready) |=> ($stable(r_out_data) && $stable(r_out_last) && $stable(r_out_chan)))
    else $error("output beat changed under backpressure");

endmodule

// File: tb/tb_amiq_muxn_arb.sv
// Directed bench for amiq_muxn_arb (N_CH=4, DATA_W=8, PKT_LOCK=1).
module tb_amiq_muxn_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  amiq_muxn_arb_if #(.N_CH(4), .DATA_W(8)) bus ();

  amiq_muxn_arb #(
    .N_CH     (4),
    .DATA_W   (8),
    .PKT_LOCK (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b0001;
    bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_last   = 4'b0000;
    bus.out_ready = 1'b1;

    // Reset: ready held low while rst is high, outputs cleared.
    tick();
    settle();
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_chan", 32'(bus.out_chan), 32'h0);
    check("rst_out_last", 32'(bus.out_last), 32'h0);
    bus.in_valid = 4'b0000;
    rst = 1'b0;

    // 1: SEL mode, sel=2.
    bus.sel      = 2'd2;
    bus.in_valid = 4'b0100;
    bus.in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    settle();
    check("t1_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    check("t1_out_valid", 32'(bus.out_valid), 32'h1);
    check("t1_out_data", 32'(bus.out_data), 32'hA5);
    check("t1_out_chan", 32'(bus.out_chan), 32'h2);
    bus.in_valid = 4'b0000;
    tick();
    check("t1_drain", 32'(bus.out_valid), 32'h0);

    // 2: SEL mode, selected channel idle -> nothing moves.
    bus.sel      = 2'd1;
    bus.in_valid = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t2_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("t2_out_valid", 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 4'b0000;

    // 3: RR, all valid, single-beat packets.
    do_reset();
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_last  = 4'b1111;
    bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    begin
      logic [1:0] exp_seq [6];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 6; i++) begin
        tick();
        check("t3_out_valid", 32'(bus.out_valid), 32'h1);
        check("t3_out_chan", 32'(bus.out_chan), 32'(exp_seq[i]));
      end
    end
    bus.in_valid = 4'b0000;
    tick();

    // 4: ch1 3-beat packet while ch0/ch2 valid. Prime rr_ptr to 0 first.
    do_reset();
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b0001;
    tick();
    check("t4_prime", 32'(bus.out_chan), 32'h0);
    bus.in_valid = 4'b0111;
    bus.in_last  = 4'b0101;
    tick();
    check("t4_b1", 32'(bus.out_chan), 32'h1);
    check("t4_b1_data", 32'(bus.out_data), 32'h11);
    tick();
    check("t4_b2", 32'(bus.out_chan), 32'h1);
    check("t4_b2_last", 32'(bus.out_last), 32'h0);
    bus.in_last = 4'b0111;
    tick();
    check("t4_b3", 32'(bus.out_chan), 32'h1);
    check("t4_b3_last", 32'(bus.out_last), 32'h1);
    tick();
    check("t4_next2", 32'(bus.out_chan), 32'h2);
    check("t4_next2_data", 32'(bus.out_data), 32'h12);
    tick();
    check("t4_next0", 32'(bus.out_chan), 32'h0);

    // 4b: same, ch1 bubbles for 2 cycles mid-packet (rr_ptr is 0 now).
    bus.in_last = 4'b0101;
    tick();
    check("t4g_b1", 32'(bus.out_chan), 32'h1);
    bus.in_valid = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("t4g_gap_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("t4g_gap_valid", 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 4'b0111;
    bus.in_last  = 4'b0111;
    tick();
    check("t4g_b2", 32'(bus.out_chan), 32'h1);
    check("t4g_b2_last", 32'(bus.out_last), 32'h1);
    tick();
    check("t4g_next2", 32'(bus.out_chan), 32'h2);
    tick();
    check("t4g_next0", 32'(bus.out_chan), 32'h0);
    bus.in_valid = 4'b0000;
    tick();

    // 5: backpressure with ch3 holding 8'h3C.
    bus.in_valid  = 4'b1000;
    bus.in_last   = 4'b1000;
    bus.in_data   = {8'h3C, 8'h12, 8'h11, 8'h10};
    bus.out_ready = 1'b0;
    tick();
    check("t5_load_valid", 32'(bus.out_valid), 32'h1);
    check("t5_load_data", 32'(bus.out_data), 32'h3C);
    check("t5_load_chan", 32'(bus.out_chan), 32'h3);
    bus.in_data = {8'hC3, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t5_hold_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("t5_hold_valid", 32'(bus.out_valid), 32'h1);
      check("t5_hold_data", 32'(bus.out_data), 32'h3C);
    end
    bus.out_ready = 1'b1;
    settle();
    check("t5_rel_ready", 32'(bus.in_ready), 32'h8);
    tick();
    check("t5_next_valid", 32'(bus.out_valid), 32'h1);
    check("t5_next_data", 32'(bus.out_data), 32'hC3);
    bus.in_valid = 4'b0000;
    tick();
    check("t5_drain", 32'(bus.out_valid), 32'h0);

    // 6: reset during a locked packet on ch2.
    bus.in_valid = 4'b0100;
    bus.in_last  = 4'b0000;
    tick();
    check("t6_b1", 32'(bus.out_chan), 32'h2);
    bus.in_valid = 4'b1111;
    tick();
    check("t6_locked", 32'(bus.out_chan), 32'h2);
    rst = 1'b1;
    settle();
    check("t6_rst_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    bus.in_last = 4'b1111;
    settle();
    check("t6_first_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("t6_first_valid", 32'(bus.out_valid), 32'h1);
    check("t6_first_chan", 32'(bus.out_chan), 32'h0);
    bus.in_valid = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/amiq_muxn_arb.md
Name: amiq_muxn_arb

Overview:
- Parametrised successor to the registered 2:1 mux. Selects one of N_CH input channels of DATA_W bits and presents it on a single registered output.
- Every channel and the output use a valid/ready handshake.
- Two selection modes: fixed select (sel port) and round-robin arbitration with optional packet lock.
- Sits between multiple stimulus or producer channels and a single downstream consumer in the blog DUT environments.

Parameters:
- N_CH, 4: number of input channels, 2..16.
- DATA_W, 8: data width per channel.
- PKT_LOCK, 1: 1 = in round-robin mode, hold the grant until in_last of the granted channel is accepted; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = SEL (fixed select), 1 = RR (round-robin).
- sel  in  $clog2(N_CH)  channel index used in SEL mode.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  N_CH  per-channel end-of-packet marker.
- in_ready  out  N_CH  per-channel ready; combinational.
- out_valid  out  1  registered output valid.
- out_data  out  DATA_W  registered output data.
- out_last  out  1  registered output last.
- out_chan  out  $clog2(N_CH)  source channel of the beat currently held.
- out_ready  in  1  downstream ready.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, out_chan=0, rr_ptr=N_CH-1 (so channel 0 has first priority), lock state=IDLE, in_ready=0 while rst is high.
- Output register load: `accept = !out_valid || out_ready`. One-deep output register, full throughput: back-to-back beats are possible while out_ready stays 1.
- Grant in SEL mode: grant = sel when in_valid[sel]=1; otherwise no grant. A sel value >= N_CH gives no grant, and no in_ready is asserted.
- Grant in RR mode: the first channel with in_valid=1, searching from rr_ptr+1 upward with wrap modulo N_CH.
- in_ready: `in_ready[i] = accept && grant_valid && (grant==i)`. At most one bit is set per cycle (one-hot or zero).
- Transfer: channel i transfers when in_valid[i] && in_ready[i]. On the next edge: out_valid=1, out_data=in_data[i], out_last=in_last[i], out_chan=i.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Output hold: when out_valid && !out_ready, out_data, out_last and out_chan hold stable and all in_ready=0.
- Output drain: when out_ready=1 and no grant, out_valid drops to 0 on the next edge.
- rr_ptr update: set to the granted channel only on a transfer in RR mode. It is unchanged in SEL mode.
- Lock FSM (RR mode with PKT_LOCK=1):
  - IDLE -> LOCKED(ch) on a transfer with in_last=0.
  - LOCKED(ch): the grant is forced to ch and other channels are ignored, even if ch drops in_valid (bubbles allowed).
  - LOCKED -> IDLE on a transfer from ch with in_last=1.
  - With PKT_LOCK=0 the FSM stays in IDLE.
- Mode change: takes effect at the next arbitration. The beat already in the output register is unaffected.
  - Switching to SEL clears the lock to IDLE on the next edge.
  - Switching to RR keeps the current rr_ptr.
- Reset mid-packet: lock is cleared, the output beat is dropped (out_valid=0), and rr_ptr returns to N_CH-1.
- Assertions required in RTL:
  - in_ready is one-hot or zero.
  - out_data, out_last and out_chan are stable while out_valid && !out_ready.

Decomposition:
- Package amiq_muxn_pkg:
  - mode enum {MODE_SEL, MODE_RR}.
  - lock state enum {LK_IDLE, LK_LOCKED}.
  - Function for rotating first-one search with wrap.
- Sub-module amiq_rr_arbiter:
  - Inputs: req[N_CH], ptr, lock_en, lock_ch.
  - Outputs: grant index and grant_valid.
  - Purely combinational; the pointer register stays in the top.

Test Plan (N_CH=4, DATA_W=8, PKT_LOCK=1 unless stated):
1. SEL mode, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
2. SEL mode, sel=1, in_valid=4'b1101 -> in_ready=0 and out_valid remains 0 for 10 cycles.
3. RR mode, all in_valid=1, all in_last=1, out_ready=1 after reset -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
4. RR mode, ch1 sends a 3-beat packet (in_last on beat 3) while ch0 and ch2 are valid -> out_chan = 1,1,1, then 2, then 0.
   - Repeat with ch1 dropping valid for 2 cycles mid-packet -> ch0 and ch2 are still not granted during the gap.
5. Backpressure: out_ready=0 for 5 cycles with ch3 valid and 8'h3C -> out_data holds 8'h3C and in_ready=0 throughout; on out_ready=1 the next beat follows with no bubble.
6. Assert rst during a locked packet on ch2 -> next cycle out_valid=0; after release, with all channels valid, the first grant is ch0.
